// File: rtl/compare_match_fifo_if.sv
// compare_match_fifo_if
//  Bundles the comparator-side inputs, the consumer handshake and the status
//  outputs of compare_match_fifo.
//  slave  : the FIFO block (receives valid_in/data_same/data/clear_alarm/out_ready,
//           drives out_valid/out_data/full/empty/count/miss_count/miss_alarm/drop)
//  master : the producer/consumer side driving the block
interface compare_match_fifo_if #(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 8
);
  logic                     valid_in;
  logic                     data_same;
  logic [DATAWIDTH-1:0]     data;
  logic                     clear_alarm;
  logic                     out_ready;
  logic                     out_valid;
  logic [DATAWIDTH-1:0]     out_data;
  logic                     full;
  logic                     empty;
  logic [$clog2(DEPTH):0]   count;
  logic [7:0]               miss_count;
  logic                     miss_alarm;
  logic                     drop;

  modport slave (
    input  valid_in, data_same, data, clear_alarm, out_ready,
    output out_valid, out_data, full, empty, count, miss_count, miss_alarm, drop
  );

  modport master (
    output valid_in, data_same, data, clear_alarm, out_ready,
    input  out_valid, out_data, full, empty, count, miss_count, miss_alarm, drop
  );
endinterface

// File: rtl/compare_match_fifo.sv
// compare_match_fifo
//  Buffers words the comparator flagged as matching in a show-ahead FIFO that is
//  drained with a valid/ready handshake, and tracks the current streak of
//  mismatches, raising a sticky alarm when the streak reaches MISS_LIMIT.
//  Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  compare_match_fifo_if.slave
//        in : valid_in, data_same, data, clear_alarm, out_ready
//        out: out_valid, out_data (head word), full, empty, count,
//             miss_count, miss_alarm, drop (one-cycle pulse for a lost match)
module compare_match_fifo #(
  parameter int DATAWIDTH  = 32,
  parameter int DEPTH      = 8,
  parameter int MISS_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  compare_match_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0]    LIMIT = 8'(MISS_LIMIT);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  function automatic logic [7:0] sat_inc(input logic [7:0] m);
    if (m >= LIMIT) return LIMIT;
    return m + 8'd1;
  endfunction

  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count_r, count_nxt;
  logic                 full_r, empty_r, drop_r;
  logic [7:0]           miss_r, miss_nxt, miss_inc;
  logic                 alarm_r, alarm_nxt;
  logic                 match, mismatch, push, pop, lost;

  // Handshake decode: a pop frees a slot in the same cycle, so a full FIFO
  // still accepts a push while the consumer drains it.
  assign match    = bus.valid_in & bus.data_same;
  assign mismatch = bus.valid_in & ~bus.data_same;
  assign pop      = ~empty_r & bus.out_ready;
  assign push     = match & (~full_r | pop);
  assign lost     = match & full_r & ~pop;

  always_comb begin
    count_nxt = count_r;
    case ({push, pop})
      2'b10:   count_nxt = count_r + CW'(1);
      2'b01:   count_nxt = count_r - CW'(1);
      default: count_nxt = count_r;
    endcase
  end

  // An alarm-setting mismatch wins over clear_alarm in the same cycle.
  always_comb begin
    miss_nxt  = miss_r;
    alarm_nxt = alarm_r;
    miss_inc  = sat_inc(miss_r);
    if (mismatch && miss_inc == LIMIT) begin
      miss_nxt  = LIMIT;
      alarm_nxt = 1'b1;
    end else if (bus.clear_alarm) begin
      miss_nxt  = 8'd0;
      alarm_nxt = 1'b0;
    end else if (match) begin
      miss_nxt  = 8'd0;
    end else if (mismatch) begin
      miss_nxt  = miss_inc;
    end
  end

  // Control state and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      drop_r  <= 1'b0;
      miss_r  <= 8'd0;
      alarm_r <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count_r <= count_nxt;
      full_r  <= (count_nxt == FULL_CNT);
      empty_r <= (count_nxt == '0);
      drop_r  <= lost;
      miss_r  <= miss_nxt;
      alarm_r <= alarm_nxt;
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= bus.data;
  end

  // Head word is forced to zero while empty so stale or uninitialised
  // storage never shows on the output; all terms are registered.
  assign bus.out_valid  = ~empty_r;
  assign bus.out_data   = empty_r ? '0 : mem[rd_ptr];
  assign bus.full       = full_r;
  assign bus.empty      = empty_r;
  assign bus.count      = count_r;
  assign bus.miss_count = miss_r;
  assign bus.miss_alarm = alarm_r;
  assign bus.drop       = drop_r;
endmodule

// File: tb/tb_compare_match_fifo.sv
module tb_compare_match_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  compare_match_fifo_if #(.DATAWIDTH(DW), .DEPTH(DEPTH)) bus ();

  compare_match_fifo #(.DATAWIDTH(DW), .DEPTH(DEPTH), .MISS_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of accepted words plus the streak/alarm state.
  logic [DW-1:0] m_q[$];
  int            m_miss  = 0;
  bit            m_alarm = 0;
  bit            m_drop  = 0;
  bit            started = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit pop, acc;
    int n;
    started = 1;
    if (rst) begin
      m_q.delete();
      m_miss  = 0;
      m_alarm = 0;
      m_drop  = 0;
    end else begin
      pop = (m_q.size() > 0) && bus.out_ready;
      acc = bus.valid_in && bus.data_same && ((m_q.size() < DEPTH) || pop);
      m_drop = bus.valid_in && bus.data_same && !acc;
      if (pop) void'(m_q.pop_front());
      if (acc) m_q.push_back(bus.data);
      if (bus.valid_in && !bus.data_same) begin
        n = (m_miss + 1 > LIMIT) ? LIMIT : m_miss + 1;
        if (n == LIMIT) begin
          m_miss  = LIMIT;
          m_alarm = 1;
        end else if (bus.clear_alarm) begin
          m_miss = 0; m_alarm = 0;
        end else m_miss = n;
      end else begin
        if (bus.valid_in) m_miss = 0;
        if (bus.clear_alarm) begin
          m_miss = 0; m_alarm = 0;
        end
      end
    end
  end

  // Monitor: compares DUT outputs with the model away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("no_x", longint'($isunknown({bus.out_valid, bus.out_data, bus.full, bus.empty,
            bus.count, bus.miss_count, bus.miss_alarm, bus.drop})), 0);
      check("out_valid", longint'(bus.out_valid), longint'(m_q.size() != 0));
      check("empty", longint'(bus.empty), longint'(m_q.size() == 0));
      check("full", longint'(bus.full), longint'(m_q.size() == DEPTH));
      check("count", longint'(bus.count), longint'(m_q.size()));
      check("drop", longint'(bus.drop), longint'(m_drop));
      check("miss_count", longint'(bus.miss_count), longint'(m_miss));
      check("miss_alarm", longint'(bus.miss_alarm), longint'(m_alarm));
      if (m_q.size() == 0)
        check("out_data_empty", longint'(bus.out_data), 0);
      else if (bus.out_valid && bus.out_ready)
        check("out_data", longint'(bus.out_data), longint'(m_q[0]));
    end
  end

  task automatic step(input logic v, input logic s, input logic [DW-1:0] d,
                      input logic clr, input logic rdy);
    bus.valid_in    = v;
    bus.data_same   = v ? s : 1'bx;
    bus.data        = d;
    bus.clear_alarm = clr;
    bus.out_ready   = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, rdy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w;
    bus.valid_in = 1'b0; bus.data_same = 1'bx; bus.data = '0;
    bus.clear_alarm = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b1;
    // 1: reset
    idle(2, 1'b0);
    check("rst_empty", longint'(bus.empty), 1);
    check("rst_count", longint'(bus.count), 0);
    check("rst_out_data", longint'(bus.out_data), 0);
    rst = 1'b0;
    idle(1, 1'b0);

    // 2: three pushes, then drain in order
    step(1, 1, 32'h11, 0, 0);
    step(1, 1, 32'h22, 0, 0);
    step(1, 1, 32'h33, 0, 0);
    idle(1, 1'b0);
    check("t2_count", longint'(bus.count), 3);
    check("t2_head0", longint'(bus.out_data), 32'h11);
    idle(1, 1'b1);
    check("t2_head1", longint'(bus.out_data), 32'h22);
    idle(1, 1'b1);
    check("t2_head2", longint'(bus.out_data), 32'h33);
    idle(1, 1'b1);
    check("t2_empty", longint'(bus.empty), 1);

    // 3: fill, overflow with and without a concurrent pop
    for (int i = 0; i < DEPTH; i++) step(1, 1, 32'h100 + i, 0, 0);
    check("t3_full", longint'(bus.full), 1);
    step(1, 1, 32'h1FF, 0, 0);
    check("t3_drop", longint'(bus.drop), 1);
    check("t3_count", longint'(bus.count), DEPTH);
    idle(1, 1'b0);
    check("t3_drop_pulse", longint'(bus.drop), 0);
    step(1, 1, 32'h1FF, 0, 1);
    check("t3_nodrop", longint'(bus.drop), 0);
    check("t3_count2", longint'(bus.count), DEPTH);
    check("t3_head", longint'(bus.out_data), 32'h101);
    idle(DEPTH + 1, 1'b1);
    check("t3_drained", longint'(bus.empty), 1);

    // 4: mismatch streak, sticky alarm, clear
    for (int i = 1; i <= LIMIT; i++) begin
      step(1, 0, 32'hDEAD, 0, 1);
      check("t4_streak", longint'(bus.miss_count), i);
    end
    check("t4_alarm", longint'(bus.miss_alarm), 1);
    step(1, 1, 32'h44, 0, 1);
    check("t4_match_zero", longint'(bus.miss_count), 0);
    check("t4_sticky", longint'(bus.miss_alarm), 1);
    step(0, 0, 0, 1, 1);
    check("t4_cleared", longint'(bus.miss_alarm), 0);

    // 5: gaps keep the streak
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);
    idle(5, 1'b1);
    check("t5_gap_hold", longint'(bus.miss_count), 3);
    step(1, 0, 0, 0, 1);
    check("t5_alarm", longint'(bus.miss_alarm), 1);
    // alarm-setting mismatch beats clear in the same cycle
    step(1, 0, 0, 1, 1);
    check("t5_win_alarm", longint'(bus.miss_alarm), 1);
    check("t5_win_count", longint'(bus.miss_count), LIMIT);
    step(0, 0, 0, 1, 1);

    // 6: reset mid-drain
    for (int i = 0; i < 5; i++) step(1, 1, 32'h500 + i, 0, 0);
    idle(2, 1'b1);
    rst = 1'b1;
    idle(1, 1'b1);
    rst = 1'b0;
    check("t6_empty", longint'(bus.empty), 1);
    check("t6_count", longint'(bus.count), 0);
    check("t6_valid", longint'(bus.out_valid), 0);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      w = $urandom;
      rst = ($urandom_range(0, 199) == 0);
      step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 2) != 0), w,
           logic'($urandom_range(0, 19) == 0), logic'($urandom_range(0, 2) == 0));
    end
    rst = 1'b0;
    idle(DEPTH + 2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
